// File: rtl/turbo_puncture_serializer.sv
// turbo_puncture_serializer
// Buffers 3-bit turbo symbols {p2, p1, sys} in a small FIFO, optionally
// punctures them to rate 1/2 and shifts the kept bits out one per handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. On the symbol side sym_ready is decoded from
// the current occupancy only. On the bit side bit_out/bit_first/bit_valid come
// from registered state only and hold steady while bit_valid && !bit_ready.
module turbo_puncture_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             rate_sel,
  input  logic             frame_sync,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_first,
  input  logic             bit_ready,
  output logic [PTR_W:0]   sym_count,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYS   = 2'd1,
    PAR_A = 2'd2,
    PAR_B = 2'd3
  } state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             load;

  state_t           state;
  state_t           next_state;
  logic [2:0]       cur_sym;
  logic             cur_rate;
  logic             phase;
  logic             phase_toggle;
  logic             sym_done;

  assign sym_ready = (count != FULL_CNT);
  assign push      = sym_valid && sym_ready;
  assign sym_count = count;
  assign state_dbg = state;

  // Symbol storage; data needs no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sym_in;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (sym_valid && !sym_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Serializer state, current symbol and puncture phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur_sym  <= '0;
      cur_rate <= 1'b0;
      phase    <= 1'b0;
    end else begin
      state <= next_state;
      if (load) begin
        cur_sym  <= mem[rd_ptr];
        cur_rate <= rate_sel;
      end
      if (frame_sync) begin
        phase <= 1'b0;
      end else if (phase_toggle) begin
        phase <= ~phase;
      end
    end
  end

  // Next-state logic; a finished symbol reloads in the same edge when possible.
  always_comb begin
    next_state   = state;
    load         = 1'b0;
    phase_toggle = 1'b0;
    sym_done     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load       = 1'b1;
          next_state = SYS;
        end
      end
      SYS: begin
        if (bit_ready) begin
          next_state = PAR_A;
        end
      end
      PAR_A: begin
        if (bit_ready) begin
          if (cur_rate) begin
            sym_done     = 1'b1;
            phase_toggle = 1'b1;
          end else begin
            next_state = PAR_B;
          end
        end
      end
      PAR_B: begin
        if (bit_ready) begin
          sym_done = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (sym_done) begin
      if (count != '0) begin
        load       = 1'b1;
        next_state = SYS;
      end else begin
        next_state = IDLE;
      end
    end
  end

  // Serial outputs decoded purely from registered state.
  always_comb begin
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    bit_first = 1'b0;
    case (state)
      SYS: begin
        bit_out   = cur_sym[0];
        bit_valid = 1'b1;
        bit_first = 1'b1;
      end
      PAR_A: begin
        bit_out   = (cur_rate && phase) ? cur_sym[2] : cur_sym[1];
        bit_valid = 1'b1;
      end
      PAR_B: begin
        bit_out   = cur_sym[2];
        bit_valid = 1'b1;
      end
      default: begin
        bit_out   = 1'b0;
        bit_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/turbo_puncture_serializer.md
Name: turbo_puncture_serializer

Overview:
- Downstream stage of the turbo encoder. Accepts 3-bit encoded symbols {p2, p1, sys} with a valid strobe and buffers them in a small FIFO.
- Applies optional rate-1/2 puncturing and serializes the kept bits onto a 1-bit stream with a valid/ready handshake toward the modulator/pin interface.
- Flags overflow, because the encoder has no backpressure input.

Parameters:
- FIFO_DEPTH, 4, symbol FIFO depth; must be a power of 2, >= 2.
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sym_in  in  3  encoded symbol: [0]=sys, [1]=p1 (encoder 1 parity), [2]=p2 (interleaved encoder parity).
- sym_valid  in  1  sym_in is valid this cycle.
- sym_ready  out  1  FIFO not full.
- rate_sel  in  1  0 = rate 1/3 (sys, p1, p2); 1 = rate 1/2 (sys, then p1/p2 alternating).
- frame_sync  in  1  one-cycle pulse; clears the puncture phase.
- bit_out  out  1  serial output bit.
- bit_valid  out  1  bit_out is valid.
- bit_first  out  1  high while bit_out is the systematic bit of a symbol.
- bit_ready  in  1  downstream accepts bit_out this cycle.
- sym_count  out  PTR_W+1  FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky; a symbol was offered while the FIFO was full.

Behaviour:
- Reset (synchronous, active-high, wins over all other events):
  - FIFO emptied; sym_count=0.
  - State=IDLE; phase=0; overflow=0.
  - bit_out=0, bit_valid=0, bit_first=0; sym_ready=1 the cycle after reset.
  - A symbol in flight mid-serialization is discarded.
- FIFO:
  - Push when sym_valid && sym_ready.
  - sym_ready = (sym_count != FIFO_DEPTH), decoded from the current count. A pop in the same cycle does not enable a push when full.
  - Push and pop in the same cycle leave sym_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Overflow: sym_valid && !sym_ready sets overflow=1 at the next edge. The symbol is dropped, and overflow holds until reset.
- Serializer FSM states: IDLE, SYS, PAR_A, PAR_B.
  - Load: pop the FIFO head into cur_sym and latch rate_sel into cur_rate. rate_sel changes mid-symbol are ignored.
  - IDLE: bit_valid=0. If sym_count!=0, load and go to SYS.
  - SYS: bit_out=cur_sym[0], bit_first=1. On bit_ready, go to PAR_A.
  - PAR_A:
    - cur_rate=0: bit_out=cur_sym[1]; on bit_ready, go to PAR_B.
    - cur_rate=1: bit_out = phase ? cur_sym[2] : cur_sym[1]; on bit_ready, toggle phase and the symbol is done.
  - PAR_B: bit_out=cur_sym[2]; on bit_ready the symbol is done.
  - Symbol done: if sym_count!=0, load and go to SYS in the same edge (no bubble); else go to IDLE.
- bit_valid=1 in SYS, PAR_A and PAR_B. bit_out, bit_valid and bit_first are decoded from registered state only; there is no combinational path from bit_ready.
- While bit_valid && !bit_ready, bit_out and bit_first hold stable.
- Latency: a symbol pushed into an empty FIFO with the FSM in IDLE at edge N is loaded at edge N+1. bit_valid=1 with the sys bit during the cycle after edge N+1.
- Throughput with bit_ready held 1: 3 bits/symbol (rate 1/3) or 2 bits/symbol (rate 1/2), continuous while the FIFO is non-empty.
- Phase:
  - Toggles only on completion of a rate-1/2 symbol.
  - frame_sync clears phase to 0 at the next edge. If it coincides with a toggle, frame_sync wins (phase=0).
  - The phase in effect during PAR_A selects the parity bit.

Test Plan:
- Rate 1/3, single push sym_in=3'b101, bit_ready=1 -> bit_out 1,0,1 on three consecutive valid cycles; bit_first=1 on the first cycle only; bit_valid=0 afterwards; first valid bit 2 edges after the push edge.
- Rate 1/2, two pushes sym_in=3'b011 -> stream 1,1,1,0 (second symbol takes p2); bit_valid continuous for 4 cycles; phase=0 at end.
- Backpressure: push one symbol, hold bit_ready=0 for 10 cycles while pushing every cycle -> bit_out/bit_first stable; sym_count reaches 4; sym_ready=0; next sym_valid sets overflow=1. Release bit_ready -> 4 more symbols drained in order with no bubble; the dropped symbol never appears.
- Rate 1/2, three symbols with p1=0, p2=1, then frame_sync pulse, then one more -> parity bits 0,1,0 for the first three; 0 (p1) for the fourth.
- Reset asserted during PAR_A with sym_count=2 -> next cycle bit_valid=0, sym_count=0, overflow=0, sym_ready=1; a subsequent push serializes normally from SYS.
- Rate 1/3, 4 pushes on consecutive cycles, bit_ready=1 -> 12 consecutive valid bits with no bubble; overflow stays 0.
